cic_decim_ctrl: RTL and testbench

Sequencer for the time-multiplexed 4-channel CIC decimator in the I2S/PDM receive path. It accepts channel-tagged input samples with a valid/ready handshake and drives the shared integrator enable/select. It keeps a decimation counter per channel and, at each decimation point, launches a token down the comb chain that enables each comb stage, with the matching channel select, on successive cycles. It also owns the clear sequencing of all stages and flags the decimated output word with its channel tag.

---
 rtl/cic_decim_ctrl.sv | 83 ++++++++
 tb/tb_cic_decim_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/cic_decim_ctrl.sv
// cic_decim_ctrl: sequencer for a time-multiplexed 4-channel CIC decimator (integrator/comb enables, clears, output tagging)
module cic_decim_ctrl #(
  parameter int NUM_STAGES = 5,
  parameter int DECIM_W    = 10
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    cfg_en_i,
  input  logic                    cfg_clr_i,
  input  logic [1:0]              cfg_ch_num_i,
  input  logic [DECIM_W-1:0]      cfg_decim_i,
  input  logic                    in_valid_i,
  input  logic [1:0]              in_ch_i,
  output logic                    in_ready_o,
  output logic                    integ_en_o,
  output logic [1:0]              integ_sel_o,
  output logic                    integ_clr_o,
  output logic [NUM_STAGES-1:0]   comb_en_o,
  output logic [2*NUM_STAGES-1:0] comb_sel_o,
  output logic                    comb_clr_o,
  output logic                    out_valid_o,
  output logic [1:0]              out_ch_o,
  output logic                    err_o
);
  typedef enum logic [1:0] {IDLE, CLEAR, RUN} state_t;
  state_t state_q, state_d;
  logic [DECIM_W-1:0] cnt_q [4];
  logic [NUM_STAGES:0] tok_v_q;
  logic [1:0] tok_ch_q [NUM_STAGES+1];
  logic [1:0] sel_q;
  logic err_q;
  logic accept, good, kill, launch;
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) state_q <= IDLE;
    else state_q <= state_d;
  always_comb
    state_d = cfg_clr_i ? CLEAR : (state_q == IDLE) ? (cfg_en_i ? CLEAR : IDLE) : (cfg_en_i ? RUN : IDLE);
  always_comb begin
    in_ready_o  = state_q == RUN;
    integ_clr_o = state_q == CLEAR;
    comb_clr_o  = state_q == CLEAR;
  end
  assign accept      = in_valid_i & in_ready_o;
  assign good        = accept & (in_ch_i <= cfg_ch_num_i);
  assign kill        = state_d == CLEAR;
  assign launch      = good & (cnt_q[in_ch_i] >= cfg_decim_i) & ~kill;
  assign integ_en_o  = good;
  assign integ_sel_o = good ? in_ch_i : sel_q;
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      sel_q <= '0;
      err_q <= 1'b0;
    end else begin
      sel_q <= integ_sel_o;
      err_q <= accept & ~good;
    end
  // the >= compare lets a ratio lowered mid-run wrap on the next accept
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (kill) cnt_q[i] <= '0;
        else if (good && in_ch_i == 2'(i)) cnt_q[i] <= (cnt_q[i] >= cfg_decim_i) ? '0 : cnt_q[i] + 1'b1;
    end
  // tags only move with their valid bit so selects hold when the pipe is empty
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      tok_v_q <= '0;
      for (int k = 0; k <= NUM_STAGES; k++) tok_ch_q[k] <= '0;
    end else begin
      tok_v_q     <= kill ? '0 : {tok_v_q[NUM_STAGES-1:0], launch};
      tok_ch_q[0] <= launch ? in_ch_i : tok_ch_q[0];
      for (int k = 1; k <= NUM_STAGES; k++) tok_ch_q[k] <= tok_v_q[k-1] ? tok_ch_q[k-1] : tok_ch_q[k];
    end
  assign comb_en_o   = tok_v_q[NUM_STAGES-1:0];
  assign out_valid_o = tok_v_q[NUM_STAGES];
  assign out_ch_o    = tok_ch_q[NUM_STAGES];
  assign err_o       = err_q;
  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_sel
    assign comb_sel_o[2*g +: 2] = tok_ch_q[g];
  end
endmodule

// File: tb/tb_cic_decim_ctrl.sv
// tb_cic_decim_ctrl: randomized scoreboard bench for cic_decim_ctrl against a per-channel sample-count model
module tb_cic_decim_ctrl;
  localparam int NS = 5;
  logic clk = 1'b0, rstn_i = 1'b0, en = 1'b0, clr = 1'b0, v = 1'b0;
  logic [1:0] ch = '0, cn = '0;
  logic [9:0] dc = '0;
  logic in_ready_o, integ_en_o, integ_clr_o, comb_clr_o, out_valid_o, err_o;
  logic [1:0] integ_sel_o, out_ch_o;
  logic [NS-1:0] comb_en_o;
  logic [2*NS-1:0] comb_sel_o;
  cic_decim_ctrl #(.NUM_STAGES(NS), .DECIM_W(10)) dut (
    .clk_i(clk), .rstn_i(rstn_i), .cfg_en_i(en), .cfg_clr_i(clr), .cfg_ch_num_i(cn), .cfg_decim_i(dc),
    .in_valid_i(v), .in_ch_i(ch), .in_ready_o(in_ready_o), .integ_en_o(integ_en_o), .integ_sel_o(integ_sel_o),
    .integ_clr_o(integ_clr_o), .comb_en_o(comb_en_o), .comb_sel_o(comb_sel_o), .comb_clr_o(comb_clr_o),
    .out_valid_o(out_valid_o), .out_ch_o(out_ch_o), .err_o(err_o));
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {int due; int ch;} tok_t;
  tok_t q[$];
  int errors = 0, checks = 0;
  int mode = 0;
  bit exp_err = 1'b0;
  int seen[4] = '{default: 0};
  bit lv[0:8191];
  int lc[0:8191];
  int rn, rd;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask
  // mode: 0 idle, 1 clearing, 2 running; launch history lv/lc indexed by accept cycle
  task automatic step(input bit e, input bit c, input bit vv, input logic [1:0] cc, input logic [1:0] n, input logic [9:0] d);
    int t, nm;
    bit good;
    logic [NS-1:0] m;
    @(posedge clk);
    #1;
    en = e; clr = c; v = vv; ch = cc; cn = n; dc = d;
    @(negedge clk);
    t = cyc;
    m = '0;
    for (int k = 0; k < NS; k++) if (t - 1 - k >= 0 && lv[t-1-k]) m[k] = 1'b1;
    chk("in_ready", in_ready_o, mode == 2);
    chk("integ_clr", integ_clr_o, mode == 1);
    chk("comb_clr", comb_clr_o, mode == 1);
    chk("err", err_o, exp_err);
    good = vv && mode == 2 && cc <= n;
    chk("integ_en", integ_en_o, good);
    if (good) chk("integ_sel", integ_sel_o, cc);
    chk("comb_en", comb_en_o, m);
    for (int k = 0; k < NS; k++) if (m[k]) chk("comb_sel", comb_sel_o[2*k +: 2], lc[t-1-k]);
    exp_err = vv && mode == 2 && !good;
    nm = c ? 1 : (mode == 0) ? (e ? 1 : 0) : (e ? 2 : 0);
    if (nm == 1) begin
      seen = '{default: 0};
      for (int i = t - NS; i <= t; i++) if (i >= 0) lv[i] = 1'b0;
      q.delete();
    end else if (good) begin
      seen[cc]++;
      if (seen[cc] == int'(d) + 1) begin
        seen[cc] = 0;
        lv[t] = 1'b1;
        lc[t] = int'(cc);
        q.push_back('{t + 1 + NS, int'(cc)});
      end
    end
    mode = nm;
  endtask
  task automatic do_reset();
    @(posedge clk);
    #2;
    rstn_i = 1'b0;
    #1;
    chk("reset_outputs", {in_ready_o, integ_en_o, integ_clr_o, comb_clr_o, comb_en_o, out_valid_o, err_o}, 0);
    en = 1'b0; clr = 1'b0; v = 1'b0;
    q.delete();
    mode = 0; exp_err = 1'b0;
    seen = '{default: 0};
    foreach (lv[i]) lv[i] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn_i = 1'b1;
  endtask
  initial forever begin
    @(posedge clk);
    #3;
    if (rstn_i) begin
      while (q.size() > 0 && q[0].due < cyc) begin
        chk("out_missing", cyc, q[0].due);
        void'(q.pop_front());
      end
      if (out_valid_o) begin
        if (q.size() == 0) chk("out_valid_spurious", out_valid_o, 0);
        else begin
          tok_t x;
          x = q.pop_front();
          chk("out_due", cyc, x.due);
          chk("out_ch", out_ch_o, x.ch);
        end
      end
    end
  end
  initial begin
    repeat (2) @(posedge clk);
    #1 rstn_i = 1'b1;
    repeat (2) step(1, 0, 0, 0, 0, 3);
    for (int i = 0; i < 12; i++) step(1, 0, 1, 0, 0, 3);
    repeat (8) step(1, 0, 0, 0, 0, 3);
    step(1, 1, 0, 0, 3, 1);
    step(1, 0, 0, 0, 3, 1);
    for (int i = 0; i < 16; i++) step(1, 0, 1, 2'(i % 4), 3, 1);
    repeat (8) step(1, 0, 0, 0, 3, 1);
    step(1, 1, 0, 0, 1, 2);
    step(1, 0, 0, 0, 1, 2);
    step(1, 0, 1, 3, 1, 2);
    step(1, 0, 1, 1, 1, 2);
    step(1, 0, 1, 1, 1, 2);
    step(1, 0, 1, 3, 1, 2);
    step(1, 0, 1, 1, 1, 2);
    repeat (8) step(1, 0, 0, 0, 1, 2);
    step(1, 1, 0, 0, 3, 1);
    step(1, 0, 0, 0, 3, 1);
    step(1, 0, 1, 0, 3, 1);
    step(1, 0, 1, 0, 3, 1);
    step(1, 0, 1, 1, 3, 1);
    step(1, 0, 1, 1, 3, 1);
    step(1, 0, 1, 0, 3, 1);
    step(1, 1, 1, 0, 3, 1);
    step(1, 0, 0, 0, 3, 1);
    for (int i = 0; i < 4; i++) step(1, 0, 1, 0, 3, 1);
    repeat (8) step(1, 0, 0, 0, 3, 1);
    step(1, 1, 0, 0, 3, 0);
    step(1, 0, 0, 0, 3, 0);
    step(1, 0, 1, 2, 3, 0);
    repeat (9) step(0, 0, 0, 0, 3, 0);
    repeat (2) step(1, 0, 0, 0, 3, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 2'($urandom_range(0, 3)), 3, 0);
    do_reset();
    repeat (3) step(1, 0, 0, 0, 3, 0);
    step(1, 0, 1, 1, 3, 0);
    rn = 3; rd = 0;
    for (int i = 0; i < 1500; i++) begin
      bit c;
      c = $urandom_range(0, 99) < 2;
      if (c) begin
        rn = $urandom_range(0, 3);
        rd = $urandom_range(0, 4);
      end
      step($urandom_range(0, 99) < 95, c, $urandom_range(0, 99) < 80, 2'($urandom_range(0, 3)), 2'(rn), 10'(rd));
    end
    repeat (NS + 3) step(0, 0, 0, 0, 2'(rn), 10'(rd));
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
